// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_queue_pkg                                           |
// | Brief    : Shared word width and NOP encoding for the IF/ID queue.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fetch_queue_pkg;

    localparam int c_WORD_LEN = 32;
    localparam logic [c_WORD_LEN-1:0] c_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_queue                                               |
// | Brief    : FWFT circular buffer of {PC, instr} between IF and ID.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int WORD_LEN = c_WORD_LEN,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WORD_LEN-1:0]     in_pc,
    input  logic [WORD_LEN-1:0]     in_instr,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [WORD_LEN-1:0]     out_pc,
    output logic [WORD_LEN-1:0]     out_instr,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [WORD_LEN-1:0] c_BUBBLE = WORD_LEN'(c_NOP);

    logic [WORD_LEN-1:0] r_pcMem    [DEPTH];
    logic [WORD_LEN-1:0] r_instrMem [DEPTH];
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    // in_ready looks only at registered occupancy, so out_ready never reaches it
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    assign out_pc    = out_valid ? r_pcMem[r_rdPtr]    : '0;
    assign out_instr = out_valid ? r_instrMem[r_rdPtr] : c_BUBBLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pcMem[i]    <= '0;
                r_instrMem[i] <= c_BUBBLE;
            end
        end else if (flush) begin
            // wrong-path fetch on the inputs is dropped along with the queue
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pcMem[r_wrPtr]    <= in_pc;
                r_instrMem[r_wrPtr] <= in_instr;
                r_wrPtr             <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the instruction-decode stage.
- Holds up to DEPTH fetched {PC, instruction} pairs in program order.
- Lets fetch keep running while decode is stalled, and discards all wrong-path entries when a branch is taken.
- Replaces the plain IF/ID register; its in_ready output becomes the fetch-stage freeze source (freeze = ~in_ready).

Parameters:
- WORD_LEN, 32, width of PC and instruction words (same value as the shared WORD_LEN define).
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid PC/instruction pair this cycle.
- in_pc  input  WORD_LEN  PC of the presented instruction.
- in_instr  input  WORD_LEN  presented instruction word.
- in_ready  output  1  queue can accept a push this cycle.
- flush  input  1  branch taken; discard all queued entries.
- out_valid  output  1  head entry is valid.
- out_pc  output  WORD_LEN  PC of head entry.
- out_instr  output  WORD_LEN  instruction of head entry.
- out_ready  input  1  decode consumes the head entry this cycle (low = decode stall).
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH entries with rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and an occupancy counter.
- Reset (rst=1 at a clock edge):
  - rd_ptr=0, wr_ptr=0, count=0, all entries cleared to 0.
  - After that edge: out_valid=0, out_pc=0, out_instr=NOP (0), in_ready=1.
  - rst takes priority over flush, push and pop.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Depends on registered count only, never on out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_pc / out_instr:
  - First-word-fall-through: combinationally driven from entry[rd_ptr] when out_valid=1.
  - Forced to 0 / NOP when empty, so decode sees a bubble.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N. Minimum IF-to-ID latency is 1 cycle, same as a pipeline register.
- Push only: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr+1; count+1.
- Pop only: rd_ptr+1; count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. Legal at any count in 1..DEPTH-1. When full, push is blocked (in_ready=0) even if pop occurs.
- Flush (flush=1, rst=0):
  - Next edge: rd_ptr=wr_ptr=0, count=0.
  - Any same-cycle push and pop are ignored: the in_* pair is from the wrong path and is dropped.
  - Entry contents need not be cleared.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Order is preserved across wrap.
- Empty with out_ready=1: no pop, no pointer change.
- in_valid=1 while full: no write, state unchanged. Fetch is frozen and must re-present the same pair.
- The queue never reorders, duplicates or drops entries, except on flush or rst.

Decomposition:
- Shared header (existing defines file): WORD_LEN and a NOP instruction constant (0).
- Pointer width and count width derived locally from DEPTH via $clog2.
- No sub-module needed. The storage array and pointer logic live in fetch_queue. Fetch and decode stages connect directly.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_pc=0x40 -> after release, count=0, out_valid=0, out_instr=0, in_ready=1.
- Fill with decode stalled: out_ready=0; push PCs 0x0,0x4,0x8,0xC in 4 cycles -> count=4, in_ready=0. A push of 0x10 is refused; out_pc stays 0x0.
- Drain with wrap: from full, out_ready=1 with in_valid=1 streaming 0x10,0x14,... -> out_pc sequence is 0x0,0x4,0x8,0xC,0x10,0x14 with no gaps. Pointers wrap past index 3, and count stays at 3 or 4 with no reorder.
- Simultaneous push and pop at count=2 -> count stays 2; the head advances by one entry and the new entry appears at the tail.
- Flush with push and pop asserted: count=3, flush=1, in_valid=1 (in_pc=0x20), out_ready=1 -> next cycle count=0, out_valid=0. A push of 0x80 the cycle after appears at out_pc=0x80 one cycle later.
- Reset mid-operation: count=3, rst=1 for 1 cycle together with flush=1 and in_valid=1 -> count=0, out_valid=0. The next push (0x100) is the head and output.
